// File: rtl/urv_divide_pkg.sv
// uRV divider shared definitions.
// Function codes, FSM states and operand helpers.
package urv_divide_pkg;

    localparam logic [2:0] FUNC_SL   = 3'b001;
    localparam logic [2:0] FUNC_SR   = 3'b101;
    localparam logic [2:0] FUNC_DIV  = 3'b100;
    localparam logic [2:0] FUNC_DIVU = 3'b101;
    localparam logic [2:0] FUNC_REM  = 3'b110;
    localparam logic [2:0] FUNC_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_FIXUP,
        DIV_DONE
    } div_state_t;

    // Magnitude of a signed operand; 0x80000000 maps to itself
    // and is then treated as unsigned by the datapath.
    function automatic logic [31:0] abs32(
        input logic [31:0] v,
        input logic        sgn
    );
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/urv_div_step.sv
// uRV divider single restoring step.
// Shift {rem,quo} left, trial-subtract, keep on no borrow.
module urv_div_step (
    input  logic [32:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] dvs,
    output logic [32:0] rem_nxt,
    output logic [31:0] quo_nxt
);

    logic [32:0] shl;
    logic [33:0] diff;
    logic        borrow;
    logic        unused_msb;

    // The partial remainder stays below the divisor, so bit 32
    // is always clear on entry; only the shifted value needs 33 bits.
    assign unused_msb = rem[32];

    // One trial subtraction against the zero-extended divisor.
    always_comb begin
        shl     = {rem[31:0], quo[31]};
        diff    = {1'b0, shl} - {2'b00, dvs};
        borrow  = diff[33];
        rem_nxt = borrow ? shl : diff[32:0];
        quo_nxt = {quo[30:0], ~borrow};
    end

endmodule

// File: rtl/urv_divide.sv
// uRV iterative divider: DIV, DIVU, REM, REMU.
// Fixed-latency restoring engine that stalls the pipeline.
module urv_divide
    import urv_divide_pkg::*;
#(
    parameter int G_BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        d_valid_i,
    input  logic        d_is_divide_i,
    input  logic [2:0]  d_fun_i,
    input  logic [31:0] d_rs1_i,
    input  logic [31:0] d_rs2_i,
    output logic        x_stall_req_o,
    output logic        x_done_o,
    output logic [31:0] w_rd_o
);

    localparam int ITERS = 32 / G_BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

    div_state_t  state_q;
    div_state_t  state_d;
    logic        accept;
    logic        stall_req;

    logic [2:0]  fun_q;
    logic        quo_neg_q;
    logic        rem_neg_q;
    logic        dbz_q;
    logic        ovf_q;
    logic [31:0] rs1_q;
    logic [31:0] dvs_q;
    logic [31:0] quo_q;
    logic [32:0] rem_q;
    logic [4:0]  cnt_q;
    logic [31:0] rd_q;

    logic        sgn;
    logic        sel_rem;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] quo_res;
    logic [31:0] rem_res;
    logic [31:0] res;

    logic [32:0] rem_c [0:G_BITS_PER_CYCLE];
    logic [31:0] quo_c [0:G_BITS_PER_CYCLE];

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar g = 0; g < G_BITS_PER_CYCLE; g++) begin : g_step
        urv_div_step u_step (
            .rem     (rem_c[g]),
            .quo     (quo_c[g]),
            .dvs     (dvs_q),
            .rem_nxt (rem_c[g+1]),
            .quo_nxt (quo_c[g+1])
        );
    end

    assign sgn = (d_fun_i == FUNC_DIV)
               | (d_fun_i == FUNC_REM);

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= DIV_IDLE;
        else       state_q <= state_d;
    end

    // Next state, accept decode and stall request.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        stall_req = 1'b0;
        unique case (state_q)
            DIV_IDLE: begin
                accept = d_valid_i & d_is_divide_i
                       & ~x_stall_i & ~x_kill_i;
                stall_req = accept;
                if (accept) state_d = DIV_BUSY;
            end
            DIV_BUSY: begin
                stall_req = 1'b1;
                if (cnt_q == 5'd0) state_d = DIV_FIXUP;
            end
            DIV_FIXUP: begin
                stall_req = 1'b1;
                state_d   = DIV_DONE;
            end
            DIV_DONE: begin
                if (!x_stall_i) state_d = DIV_IDLE;
            end
        endcase
        if (x_kill_i) state_d = DIV_IDLE;
    end

    // Sign fixup and special-case override of the raw result.
    always_comb begin
        q_fix = quo_neg_q ? -quo_q : quo_q;
        r_fix = rem_neg_q ? -rem_q[31:0] : rem_q[31:0];
        unique case (1'b1)
            dbz_q: begin
                quo_res = 32'hFFFF_FFFF;
                rem_res = rs1_q;
            end
            ovf_q: begin
                quo_res = 32'h8000_0000;
                rem_res = 32'h0;
            end
            default: begin
                quo_res = q_fix;
                rem_res = r_fix;
            end
        endcase
        sel_rem = (fun_q == FUNC_REM)
                | (fun_q == FUNC_REMU);
        res = sel_rem ? rem_res : quo_res;
    end

    // Operand latch, iteration and result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fun_q     <= 3'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            rs1_q     <= 32'h0;
            dvs_q     <= 32'h0;
            quo_q     <= 32'h0;
            rem_q     <= 33'h0;
            cnt_q     <= 5'h0;
            rd_q      <= 32'h0;
        end else if (accept) begin
            fun_q     <= d_fun_i;
            quo_neg_q <= sgn & (d_rs1_i[31] ^ d_rs2_i[31]);
            rem_neg_q <= sgn & d_rs1_i[31];
            dbz_q     <= (d_rs2_i == 32'h0);
            ovf_q     <= sgn
                       & (d_rs1_i == 32'h8000_0000)
                       & (d_rs2_i == 32'hFFFF_FFFF);
            rs1_q     <= d_rs1_i;
            dvs_q     <= abs32(d_rs2_i, sgn);
            quo_q     <= abs32(d_rs1_i, sgn);
            rem_q     <= 33'h0;
            cnt_q     <= CNT_LAST;
        end else if (state_q == DIV_BUSY) begin
            rem_q <= rem_c[G_BITS_PER_CYCLE];
            quo_q <= quo_c[G_BITS_PER_CYCLE];
            if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end else if (state_q == DIV_FIXUP && !x_kill_i) begin
            rd_q <= res;
        end
    end

    assign x_stall_req_o = stall_req;
    assign x_done_o      = (state_q == DIV_DONE);
    assign w_rd_o        = rd_q;

endmodule

// File: tb/tb_urv_divide.sv
// Directed bench for urv_divide.
// Runs G=1 and G=2 instances side by side on shared inputs.
module tb_urv_divide;

    logic        clk;
    logic        rst;
    logic        x_stall;
    logic        x_kill;
    logic        d_valid;
    logic        d_is_div;
    logic [2:0]  d_fun;
    logic [31:0] rs1;
    logic [31:0] rs2;

    logic        sr1, done1;
    logic [31:0] rd1;
    logic        sr2, done2;
    logic [31:0] rd2;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    urv_divide #(.G_BITS_PER_CYCLE(1)) u_dut1 (
        .clk_i         (clk),
        .rst_i         (rst),
        .x_stall_i     (x_stall),
        .x_kill_i      (x_kill),
        .d_valid_i     (d_valid),
        .d_is_divide_i (d_is_div),
        .d_fun_i       (d_fun),
        .d_rs1_i       (rs1),
        .d_rs2_i       (rs2),
        .x_stall_req_o (sr1),
        .x_done_o      (done1),
        .w_rd_o        (rd1)
    );

    urv_divide #(.G_BITS_PER_CYCLE(2)) u_dut2 (
        .clk_i         (clk),
        .rst_i         (rst),
        .x_stall_i     (x_stall),
        .x_kill_i      (x_kill),
        .d_valid_i     (d_valid),
        .d_is_divide_i (d_is_div),
        .d_fun_i       (d_fun),
        .d_rs1_i       (rs1),
        .d_rs2_i       (rs2),
        .x_stall_req_o (sr2),
        .x_done_o      (done2),
        .w_rd_o        (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic issue(
        input logic [2:0]  f,
        input logic [31:0] a,
        input logic [31:0] b
    );
        @(negedge clk);
        d_valid  = 1'b1;
        d_is_div = 1'b1;
        d_fun    = f;
        rs1      = a;
        rs2      = b;
        #1;
        check("acc_stall", 32'(sr1), 32'd1);
        @(posedge clk);
        #1;
        d_valid  = 1'b0;
        d_is_div = 1'b0;
    endtask

    task automatic op(
        input logic [2:0]  f,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] exp,
        input string       tag
    );
        int lat1, lat2, bad;
        logic [31:0] r1, r2;
        lat1 = -1; lat2 = -1; bad = 0;
        r1 = 32'h0; r2 = 32'h0;
        issue(f, a, b);
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (done1 && lat1 < 0) begin
                lat1 = c; r1 = rd1;
            end
            if (done2 && lat2 < 0) begin
                lat2 = c; r2 = rd2;
            end
            if (sr1 !== (c <= 33)) bad++;
            if (c == 35 && done1 !== 1'b0) bad++;
        end
        check({tag, " lat1"}, 32'(lat1), 32'd34);
        check({tag, " rd1"}, r1, exp);
        check({tag, " stall/drop"}, 32'(bad), 32'd0);
        check({tag, " hold1"}, rd1, exp);
        check({tag, " lat2"}, 32'(lat2), 32'd18);
        check({tag, " rd2"}, r2, exp);
    endtask

    initial begin
        int bad;
        rst      = 1'b1;
        x_stall  = 1'b0;
        x_kill   = 1'b0;
        d_valid  = 1'b0;
        d_is_div = 1'b0;
        d_fun    = 3'b0;
        rs1      = 32'h0;
        rs2      = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst done", 32'(done1), 32'd0);
        check("rst rd", rd1, 32'h0);
        check("rst stall", 32'(sr1), 32'd0);

        op(F_DIVU, 32'd100, 32'd7, 32'd14, "divu");
        op(F_REMU, 32'd100, 32'd7, 32'd2, "remu");
        op(F_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, "div neg");
        op(F_REM, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, "rem neg");
        op(F_REM, 32'd7, 32'hFFFF_FFFE,
           32'd1, "rem negdiv");
        op(F_DIV, 32'd5, 32'd0,
           32'hFFFF_FFFF, "div0 pos");
        op(F_DIV, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFF, "div0 neg");
        op(F_REMU, 32'd5, 32'd0, 32'd5, "remu0");
        op(F_REM, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFB, "rem0 neg");
        op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, "div ovf");
        op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, "rem ovf");
        op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, "divu big");

        // Kill in the same cycle as a would-be accept.
        @(negedge clk);
        d_valid  = 1'b1;
        d_is_div = 1'b1;
        d_fun    = F_DIVU;
        rs1      = 32'd100;
        rs2      = 32'd7;
        x_kill   = 1'b1;
        #1;
        check("kill blk stall", 32'(sr1), 32'd0);
        @(posedge clk);
        #1;
        d_valid  = 1'b0;
        d_is_div = 1'b0;
        x_kill   = 1'b0;
        bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done1 || sr1) bad++;
        end
        check("kill blk idle", 32'(bad), 32'd0);

        // Flush mid-operation, then a fresh accept.
        issue(F_DIVU, 32'd100, 32'd7);
        bad = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done1) bad++;
            if (c == 10) x_kill = 1'b1;
        end
        @(posedge clk);
        #1 x_kill = 1'b0;
        check("flush nodone", 32'(bad), 32'd0);
        check("flush stall", 32'(sr1), 32'd0);
        check("flush done1", 32'(done1), 32'd0);
        check("flush done2", 32'(done2), 32'd0);
        op(F_DIVU, 32'd9, 32'd3, 32'd3, "post flush");

        // Stall held in DONE keeps the result presented.
        issue(F_DIVU, 32'd100, 32'd7);
        bad = 0;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            if (c == 37) x_stall = 1'b0;
            if (done1 !== (c >= 34 && c <= 37)) bad++;
            if (c >= 34 && c <= 37 && rd1 !== 32'd14) bad++;
            if (c == 34) x_stall = 1'b1;
        end
        check("hold done/rd", 32'(bad), 32'd0);

        // Reset mid-operation abandons it.
        issue(F_DIVU, 32'd100, 32'd7);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 20) rst = 1'b1;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst mid rd", rd1, 32'h0);
        check("rst mid done", 32'(done1), 32'd0);
        check("rst mid stall", 32'(sr1), 32'd0);
        bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done1) bad++;
        end
        check("rst no done", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/urv_divide.md
Name: urv_divide

Overview:
- Iterative restoring divider for the uRV execute stage; implements RV32M DIV, DIVU, REM and REMU.
- Complements the single-pass barrel shifter: a multi-cycle shift-and-subtract engine that owns the pipeline stall while it runs.
- Sits beside the shifter and ALU. Takes decode-stage operands and returns the result on the writeback path.

Parameters:
- G_BITS_PER_CYCLE, 1, quotient bits resolved per clock. Legal values are 1 or 2. Iteration count is 32/G_BITS_PER_CYCLE.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- x_stall_i  in  1  pipeline stall; holds a finished result
- x_kill_i  in  1  flush; aborts any operation in flight
- d_valid_i  in  1  decode slot valid
- d_is_divide_i  in  1  instruction is DIV/DIVU/REM/REMU
- d_fun_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- d_rs1_i  in  32  dividend
- d_rs2_i  in  32  divisor
- x_stall_req_o  out  1  divider requests pipeline stall
- x_done_o  out  1  result valid on w_rd_o
- w_rd_o  out  32  quotient or remainder

Behaviour:
- Clocking/reset: one clock, clk_i. rst_i is synchronous and active-high. Reset values: state IDLE, w_rd_o = 0, x_done_o = 0, all internal registers 0. A reset during BUSY or FIXUP abandons the operation; no done pulse follows.
- Accept condition: state IDLE && d_valid_i && d_is_divide_i && !x_stall_i && !x_kill_i. This is cycle N.
- On accept, latch:
  - function code;
  - sign flags: signed = (fun is DIV or REM);
  - |rs1| and |rs2| when signed, raw operands otherwise;
  - div-by-zero flag (rs2 == 0);
  - overflow flag (signed && rs1 == 0x80000000 && rs2 == 0xFFFFFFFF).
- States:
  - IDLE -> BUSY on accept.
  - BUSY: each cycle performs G_BITS_PER_CYCLE restoring steps:
    - {rem,quo} shifts left by 1;
    - trial = rem - divisor;
    - if no borrow, rem = trial and the quotient LSB = 1.
    - A 5-bit down-counter reaches 0, then -> FIXUP.
  - FIXUP, one cycle, selects the result:
    - div-by-zero: quotient 0xFFFFFFFF, remainder = original rs1.
    - overflow: quotient 0x80000000, remainder 0.
    - otherwise: negate the quotient if sign(rs1)^sign(rs2) for DIV; negate the remainder if sign(rs1) for REM.
    - REM/REMU select the remainder, DIV/DIVU the quotient. Register the selection into w_rd_o, then -> DONE.
  - DONE: x_done_o = 1 and w_rd_o is stable. Stay in DONE while x_stall_i = 1; -> IDLE on the first cycle with x_stall_i = 0. x_done_o drops and w_rd_o is held until the next FIXUP.
- Latency:
  - G=1: x_done_o first asserts at cycle N+34.
  - G=2: x_done_o first asserts at cycle N+18.
  - Latency is fixed; special cases (div-by-zero, overflow) do not shorten it.
- x_stall_req_o, combinational: high in the accept cycle and throughout BUSY and FIXUP; low in IDLE (when not accepting) and in DONE.
- x_stall_i is ignored in BUSY and FIXUP.
- x_kill_i: any state -> IDLE on the next edge. x_done_o = 0 from that edge; w_rd_o is unchanged. x_kill_i in the same cycle as a would-be accept blocks the accept.
- Back-to-back: a new accept is possible in the first IDLE cycle after DONE. There is no accept in the DONE-exit cycle itself.
- Width rules:
  - Remainder register is 33 bits so the subtract borrow is observed.
  - Negation is two's complement in 32 bits.
  - |0x80000000| = 0x80000000 is treated as unsigned.

Decomposition:
- Add to urv_defs.v:
  - FUNC_DIV, FUNC_DIVU, FUNC_REM and FUNC_REMU, alongside the existing FUNC_SL/FUNC_SR;
  - state encodings DIV_IDLE, DIV_BUSY, DIV_FIXUP, DIV_DONE.
- One natural sub-module: urv_div_step. It is a combinational single restoring step (33-bit rem, 32-bit quo, 32-bit divisor in; next rem/quo out). It is instantiated G_BITS_PER_CYCLE times in a chain.

Test Plan:
- DIVU 100/7, G=1, accept at cycle 0 -> x_stall_req_o high for cycles 0..33; x_done_o at cycle 34; w_rd_o = 14. REMU same operands -> 2.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). REM 7 / 0xFFFFFFFE -> 1.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF;
  - DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF;
  - REMU 5/0 -> 5;
  - REM 0xFFFFFFFB/0 -> 0xFFFFFFFB;
  - all at the full fixed latency.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0. DIVU 0x80000000 / 0xFFFFFFFF -> 0.
- Flush: x_kill_i pulsed at cycle N+10 -> IDLE at N+11, x_stall_req_o low, no x_done_o. A new DIVU 9/3 accepted at N+11 -> 3 at N+45.
- Hold and reset: x_stall_i held high for 3 cycles in DONE -> x_done_o and w_rd_o = 14 stable for 4 cycles, then IDLE. rst_i at N+20 -> IDLE, w_rd_o = 0, x_done_o never asserts.
